// File: rtl/random_32_check.sv
// Receiving-end checker for a 32-bit LFSR word stream: self-synchronises,
// predicts each next word, reports lock/mismatches and keeps saturating stats.
module random_32_check #(
    parameter int LOCK_WORDS = 2,
    parameter int LOSS_ERRS  = 3,
    parameter int CNT_W      = 16
) (
    input  logic             rand_clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [31:0]      in_value,
    input  logic             clear_stats,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [31:0] LOCKUP_WORD = 32'hFFFF_FFFF;
    localparam logic [3:0]  LOCK_TGT    = 4'(LOCK_WORDS);
    localparam logic [3:0]  LOSS_TGT    = 4'(LOSS_ERRS);

    function automatic logic [31:0] lfsrNext(input logic [31:0] v);
        return {v[30:0], ~(v[31] ^ v[21] ^ v[1] ^ v[0])};
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      pred_q, pred_d;
    logic [3:0]       goodRun_q, goodRun_d;
    logic [3:0]       badRun_q, badRun_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic             isMatch;

    assign isMatch = (in_value == pred_q);

    always_ff @(posedge rand_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= SEARCH;
            pred_q    <= '0;
            goodRun_q <= '0;
            badRun_q  <= '0;
            error_q   <= 1'b0;
            errCnt_q  <= '0;
            wordCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            goodRun_q <= goodRun_d;
            badRun_q  <= badRun_d;
            error_q   <= error_d;
            errCnt_q  <= errCnt_d;
            wordCnt_q <= wordCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        goodRun_d = goodRun_q;
        badRun_d  = badRun_q;
        error_d   = 1'b0;
        errCnt_d  = errCnt_q;
        wordCnt_d = wordCnt_q;

        if (in_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (in_value != LOCKUP_WORD) begin
                        pred_d    = lfsrNext(in_value);
                        goodRun_d = '0;
                        state_d   = VERIFY;
                    end
                end
                VERIFY: begin
                    if (isMatch) begin
                        pred_d    = lfsrNext(pred_q);
                        goodRun_d = goodRun_q + 4'd1;
                        if ((goodRun_q + 4'd1) == LOCK_TGT) begin
                            state_d  = LOCKED;
                            badRun_d = '0;
                        end
                    end else if (in_value == LOCKUP_WORD) begin
                        goodRun_d = '0;
                        state_d   = SEARCH;
                    end else begin
                        pred_d    = lfsrNext(in_value);
                        goodRun_d = '0;
                    end
                end
                LOCKED: begin
                    // The predictor freewheels on mismatches so a single corrupted
                    // word does not throw away synchronisation.
                    pred_d = lfsrNext(pred_q);
                    if (wordCnt_q != '1) begin
                        wordCnt_d = wordCnt_q + CNT_W'(1);
                    end
                    if (isMatch) begin
                        badRun_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (errCnt_q != '1) begin
                            errCnt_d = errCnt_q + CNT_W'(1);
                        end
                        if ((badRun_q + 4'd1) == LOSS_TGT) begin
                            badRun_d = '0;
                            state_d  = SEARCH;
                        end else begin
                            badRun_d = badRun_q + 4'd1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clear_stats) begin
            errCnt_d  = '0;
            wordCnt_d = '0;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign error      = error_q;
    assign err_count  = errCnt_q;
    assign word_count = wordCnt_q;

endmodule

// File: tb/tb_random_32_check.sv
// Directed self-checking bench for random_32_check with hand-computed LFSR words.
module tb_random_32_check;

    localparam int CNT_W = 4;

    logic             rand_clk = 1'b0;
    logic             Reset;
    logic             in_valid;
    logic [31:0]      in_value;
    logic             clear_stats;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    int assertCount = 0;
    int failCount   = 0;

    random_32_check #(
        .LOCK_WORDS(2),
        .LOSS_ERRS (3),
        .CNT_W     (CNT_W)
    ) dut (
        .rand_clk   (rand_clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .clear_stats(clear_stats),
        .locked     (locked),
        .error      (error),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 rand_clk = ~rand_clk;

    function automatic logic [31:0] nextWord(input logic [31:0] v);
        return {v[30:0], ~(v[31] ^ v[21] ^ v[1] ^ v[0])};
    endfunction

    // One valid word sampled on the next rising edge; outputs observed 1 after it.
    task automatic sendWord(input logic [31:0] v, input logic clr);
        @(negedge rand_clk);
        in_valid    = 1'b1;
        in_value    = v;
        clear_stats = clr;
        @(posedge rand_clk);
        #1;
        in_valid    = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic idleCycle(input logic clr);
        @(negedge rand_clk);
        in_valid    = 1'b0;
        clear_stats = clr;
        @(posedge rand_clk);
        #1;
        clear_stats = 1'b0;
    endtask

    task automatic doReset();
        @(negedge rand_clk);
        Reset = 1'b1;
        @(negedge rand_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        clear_stats = 1'b0;
        repeat (2) @(posedge rand_clk);
        #1;
        assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL reset_locked got %b want 0", locked); end
        assertCount++; if (error !== 1'b0) begin failCount++; $display("[TB] FAIL reset_error got %b want 0", error); end
        assertCount++; if (err_count !== 4'd0) begin failCount++; $display("[TB] FAIL reset_err_count got %0d want 0", err_count); end
        assertCount++; if (word_count !== 4'd0) begin failCount++; $display("[TB] FAIL reset_word_count got %0d want 0", word_count); end
        @(negedge rand_clk);
        Reset = 1'b0;
    endtask

    task automatic test_lock();
        sendWord(32'h1, 1'b0);
        assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL lock_after_seed got %b want 0", locked); end
        sendWord(32'h2, 1'b0);
        assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL lock_after_1st got %b want 0", locked); end
        assertCount++; if (word_count !== 4'd0) begin failCount++; $display("[TB] FAIL verify_no_count got %0d want 0", word_count); end
        sendWord(32'h4, 1'b0);
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL lock_after_2nd got %b want 1", locked); end
        sendWord(32'h9, 1'b0);
        assertCount++; if (error !== 1'b0) begin failCount++; $display("[TB] FAIL lock_match_error got %b want 0", error); end
        assertCount++; if (word_count !== 4'd1) begin failCount++; $display("[TB] FAIL lock_word_count got %0d want 1", word_count); end
        assertCount++; if (err_count !== 4'd0) begin failCount++; $display("[TB] FAIL lock_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        sendWord(32'h13, 1'b0);
        assertCount++; if (error !== 1'b1) begin failCount++; $display("[TB] FAIL single_err_pulse got %b want 1", error); end
        assertCount++; if (err_count !== 4'd1) begin failCount++; $display("[TB] FAIL single_err_count got %0d want 1", err_count); end
        assertCount++; if (word_count !== 4'd2) begin failCount++; $display("[TB] FAIL single_word_count got %0d want 2", word_count); end
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL single_locked got %b want 1", locked); end
        idleCycle(1'b0);
        assertCount++; if (error !== 1'b0) begin failCount++; $display("[TB] FAIL single_pulse_width got %b want 0", error); end
        assertCount++; if (word_count !== 4'd2) begin failCount++; $display("[TB] FAIL idle_word_count got %0d want 2", word_count); end
        sendWord(32'h24, 1'b0);
        assertCount++; if (error !== 1'b0) begin failCount++; $display("[TB] FAIL freewheel_match got %b want 0", error); end
        assertCount++; if (word_count !== 4'd3) begin failCount++; $display("[TB] FAIL freewheel_word_count got %0d want 3", word_count); end
    endtask

    // Expected next word is 0x49; bad_run must have been cleared by the 0x24 match.
    task automatic test_loss();
        sendWord(32'h0, 1'b0);
        assertCount++; if (error !== 1'b1 || locked !== 1'b1) begin failCount++; $display("[TB] FAIL loss_1st got err=%b lk=%b want err=1 lk=1", error, locked); end
        sendWord(32'h0, 1'b0);
        assertCount++; if (error !== 1'b1 || locked !== 1'b1) begin failCount++; $display("[TB] FAIL loss_2nd got err=%b lk=%b want err=1 lk=1", error, locked); end
        sendWord(32'h0, 1'b0);
        assertCount++; if (error !== 1'b1 || locked !== 1'b0) begin failCount++; $display("[TB] FAIL loss_3rd got err=%b lk=%b want err=1 lk=0", error, locked); end
        assertCount++; if (err_count !== 4'd4) begin failCount++; $display("[TB] FAIL loss_err_count got %0d want 4", err_count); end
        assertCount++; if (word_count !== 4'd6) begin failCount++; $display("[TB] FAIL loss_word_count got %0d want 6", word_count); end
        sendWord(32'h0, 1'b0);
        assertCount++; if (error !== 1'b0 || locked !== 1'b0) begin failCount++; $display("[TB] FAIL relock_seed got err=%b lk=%b want err=0 lk=0", error, locked); end
        sendWord(32'h1, 1'b0);
        sendWord(32'h2, 1'b0);
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL relock got %b want 1", locked); end
        assertCount++; if (err_count !== 4'd4) begin failCount++; $display("[TB] FAIL relock_err_count got %0d want 4", err_count); end
    endtask

    task automatic test_async_reset();
        sendWord(32'h55, 1'b0);
        sendWord(32'h9, 1'b0);
        assertCount++; if (err_count !== 4'd5 || locked !== 1'b1) begin failCount++; $display("[TB] FAIL pre_reset got ec=%0d lk=%b want ec=5 lk=1", err_count, locked); end
        assertCount++; if (word_count !== 4'd8) begin failCount++; $display("[TB] FAIL pre_reset_wc got %0d want 8", word_count); end
        @(negedge rand_clk);
        #2;
        Reset = 1'b1;
        #1;
        assertCount++; if (locked !== 1'b0 || error !== 1'b0) begin failCount++; $display("[TB] FAIL async_reset_flags got lk=%b err=%b want 0 0", locked, error); end
        assertCount++; if (err_count !== 4'd0 || word_count !== 4'd0) begin failCount++; $display("[TB] FAIL async_reset_counts got ec=%0d wc=%0d want 0 0", err_count, word_count); end
        @(negedge rand_clk);
        Reset = 1'b0;
    endtask

    task automatic test_search_lockup();
        for (int i = 0; i < 5; i++) begin
            sendWord(32'hFFFF_FFFF, 1'b0);
        end
        sendWord(32'h1, 1'b0);
        assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL lockup_held got %b want 0", locked); end
        doReset();
        for (int i = 0; i < 5; i++) begin
            sendWord(32'hFFFF_FFFF, 1'b0);
        end
        sendWord(32'h0, 1'b0);
        sendWord(32'h1, 1'b0);
        assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL lockup_early got %b want 0", locked); end
        sendWord(32'h2, 1'b0);
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL lockup_relock got %b want 1", locked); end
    endtask

    // A mismatch in VERIFY reseeds from the received word: 5 -> 0xA -> 0x14.
    task automatic test_verify_reseed();
        doReset();
        sendWord(32'h1, 1'b0);
        sendWord(32'h5, 1'b0);
        sendWord(32'hA, 1'b0);
        assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL reseed_early got %b want 0", locked); end
        sendWord(32'h14, 1'b0);
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL reseed_lock got %b want 1", locked); end
        assertCount++; if (err_count !== 4'd0 || word_count !== 4'd0) begin failCount++; $display("[TB] FAIL reseed_counts got ec=%0d wc=%0d want 0 0", err_count, word_count); end
    endtask

    task automatic test_clear_stats();
        doReset();
        sendWord(32'h1, 1'b0);
        sendWord(32'h2, 1'b0);
        sendWord(32'h4, 1'b0);
        sendWord(32'h9, 1'b0);
        sendWord(32'h13, 1'b1);
        assertCount++; if (error !== 1'b1) begin failCount++; $display("[TB] FAIL clear_err_pulse got %b want 1", error); end
        assertCount++; if (err_count !== 4'd0 || word_count !== 4'd0) begin failCount++; $display("[TB] FAIL clear_wins got ec=%0d wc=%0d want 0 0", err_count, word_count); end
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL clear_locked got %b want 1", locked); end
        sendWord(32'h24, 1'b0);
        assertCount++; if (word_count !== 4'd1 || error !== 1'b0) begin failCount++; $display("[TB] FAIL clear_after got wc=%0d err=%b want 1 0", word_count, error); end
        idleCycle(1'b1);
        assertCount++; if (word_count !== 4'd0) begin failCount++; $display("[TB] FAIL clear_idle got %0d want 0", word_count); end
    endtask

    task automatic test_saturation();
        logic [31:0] p;
        doReset();
        sendWord(32'h1, 1'b0);
        sendWord(32'h2, 1'b0);
        sendWord(32'h4, 1'b0);
        p = 32'h9;
        for (int i = 0; i < 20; i++) begin
            sendWord(p, 1'b0);
            p = nextWord(p);
        end
        assertCount++; if (word_count !== 4'hF || err_count !== 4'd0) begin failCount++; $display("[TB] FAIL sat_word got wc=%0d ec=%0d want 15 0", word_count, err_count); end
        for (int i = 0; i < 17; i++) begin
            sendWord(p ^ 32'h1, 1'b0);
            p = nextWord(p);
            sendWord(p, 1'b0);
            p = nextWord(p);
        end
        assertCount++; if (err_count !== 4'hF || word_count !== 4'hF) begin failCount++; $display("[TB] FAIL sat_err got ec=%0d wc=%0d want 15 15", err_count, word_count); end
        assertCount++; if (locked !== 1'b1) begin failCount++; $display("[TB] FAIL sat_locked got %b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_async_reset();
        test_search_lockup();
        test_verify_reseed();
        test_clear_stats();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
